// File: rtl/auc_naf_dec.sv
// rtl/auc_naf_dec.sv - NAF digit-stream decoder reconstructing a WIDTH-bit scalar
module auc_naf_dec #(
    parameter int WIDTH = 256,
    parameter int CBIT  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_start,
    input  logic             dec_hold,
    input  logic             naf_shft_rdy,
    input  logic [4:0]       naf_shft_vlue,
    input  logic             naf_shft_last,
    output logic             naf_shft_en,
    output logic [WIDTH-1:0] dec_dout,
    output logic             dec_vld,
    output logic             dec_err,
    output logic [CBIT:0]    dec_len,
    output logic             dec_busy
);

    typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [WIDTH+1:0] acc, acc_nxt, digit;
    logic [CBIT:0]           cnt, cnt_nxt;
    logic                    err, err_nxt, res_err;
    logic                    illegal, accept, overflow, finish;
    logic [2:0]              mag;

    // One-hot magnitude {num1,num3,num5,num7}; a signed zero is not a valid digit.
    always_comb begin
        mag     = 3'd0;
        illegal = 1'b0;
        case (naf_shft_vlue[3:0])
            4'b1000: mag = 3'd1;
            4'b0100: mag = 3'd3;
            4'b0010: mag = 3'd5;
            4'b0001: mag = 3'd7;
            4'b0000: illegal = naf_shft_vlue[4];
            default: illegal = 1'b1;
        endcase
        digit = $signed({{(WIDTH-1){1'b0}}, mag});
        if (naf_shft_vlue[4] && !illegal)
            digit = -digit;
    end

    assign naf_shft_en = (state == SHIFT) & naf_shft_rdy & ~dec_hold;
    // A restart in the same cycle wins over the digit on the bus.
    assign accept      = naf_shft_en & ~dec_start;

    assign acc_nxt  = (acc <<< 1) + digit;
    assign cnt_nxt  = cnt + 1'b1;
    assign overflow = (cnt_nxt == (CBIT+1)'(WIDTH + 2));
    assign finish   = accept & (naf_shft_last | overflow);
    assign err_nxt  = err | illegal | (overflow & ~naf_shft_last);
    assign res_err  = err_nxt | (acc_nxt[WIDTH+1:WIDTH] != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (dec_start) state_nxt = WAIT;
            WAIT:  if (dec_start) state_nxt = WAIT;
                   else if (naf_shft_rdy) state_nxt = SHIFT;
            SHIFT: if (dec_start) state_nxt = WAIT;
                   else if (finish) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            dec_dout <= '0;
            dec_err  <= 1'b0;
            dec_len  <= '0;
        end else begin
            state <= state_nxt;
            if (dec_start && state != DONE) begin
                acc <= '0;
                cnt <= '0;
                err <= 1'b0;
            end else if (accept) begin
                acc <= acc_nxt;
                cnt <= cnt_nxt;
                err <= err_nxt;
                if (finish) begin
                    dec_dout <= acc_nxt[WIDTH-1:0];
                    dec_err  <= res_err;
                    dec_len  <= cnt_nxt;
                end
            end
        end
    end

    assign dec_vld  = (state == DONE);
    assign dec_busy = (state != IDLE);

endmodule

// File: tb/tb_auc_naf_dec.sv
// tb/tb_auc_naf_dec.sv - directed self-checking bench for auc_naf_dec
module tb_auc_naf_dec;

    localparam int WIDTH = 256;
    localparam int CBIT  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dec_start = 1'b0;
    logic             dec_hold = 1'b0;
    logic             naf_shft_rdy = 1'b0;
    logic [4:0]       naf_shft_vlue;
    logic             naf_shft_last;
    logic             naf_shft_en;
    logic [WIDTH-1:0] dec_dout;
    logic             dec_vld;
    logic             dec_err;
    logic [CBIT:0]    dec_len;
    logic             dec_busy;

    auc_naf_dec #(.WIDTH(WIDTH), .CBIT(CBIT)) dut (
        .clk(clk), .rst(rst), .dec_start(dec_start), .dec_hold(dec_hold),
        .naf_shft_rdy(naf_shft_rdy), .naf_shft_vlue(naf_shft_vlue),
        .naf_shft_last(naf_shft_last), .naf_shft_en(naf_shft_en),
        .dec_dout(dec_dout), .dec_vld(dec_vld), .dec_err(dec_err),
        .dec_len(dec_len), .dec_busy(dec_busy)
    );

    always #5 clk = ~clk;

    // Digit producer: presents dg[idx], advances on each accept strobe.
    logic [4:0] dg [8];
    int ndig = 0, idx = 0, pulses = 0, vld_cnt = 0, cyc = 0, acc_cyc = 0;
    logic load = 1'b0;
    int n_assert = 0, n_fail = 0;
    int p0, v0;

    assign naf_shft_vlue = dg[idx[2:0]];
    assign naf_shft_last = (idx == ndig - 1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) idx <= 0;
        else if (naf_shft_en) idx <= idx + 1;
        if (naf_shft_en) pulses <= pulses + 1;
        if (naf_shft_en && naf_shft_last) acc_cyc <= cyc;
        if (dec_vld) vld_cnt <= vld_cnt + 1;
    end

    task automatic chk(input string tag, input logic [259:0] obs, input logic [259:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_stream(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                              input logic [4:0] d, input logic [4:0] e, input int n);
        dg[0] = a; dg[1] = b; dg[2] = c; dg[3] = d; dg[4] = e;
        dg[5] = 5'b0; dg[6] = 5'b0; dg[7] = 5'b0;
        ndig = n;
    endtask

    task automatic start_stream();
        @(negedge clk);
        load = 1'b1; dec_start = 1'b1;
        @(negedge clk);
        load = 1'b0; dec_start = 1'b0;
    endtask

    task automatic wait_vld();
        for (int k = 0; k < 60 && !dec_vld; k++) @(negedge clk);
        chk("vld_seen", dec_vld, 1'b1);
    endtask

    task automatic wait_pulses(input int n);
        for (int k = 0; k < 60 && pulses < n; k++) @(negedge clk);
        chk("pulses_reach", pulses >= n, 1'b1);
    endtask

    initial begin
        set_stream(5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 0);
        repeat (2) @(negedge clk);
        chk("rst_dout", dec_dout, 0);
        chk("rst_err", dec_err, 0);
        chk("rst_len", dec_len, 0);
        chk("rst_vld", dec_vld, 0);
        chk("rst_busy", dec_busy, 0);
        chk("rst_en", naf_shft_en, 0);
        rst = 1'b0;

        // 1,0,0,0,+7 -> 23
        set_stream(5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5);
        naf_shft_rdy = 1'b1;
        p0 = pulses;
        start_stream();
        chk("busy_after_start", dec_busy, 1);
        wait_vld();
        chk("s23_dout", dec_dout, 23);
        chk("s23_len", dec_len, 5);
        chk("s23_err", dec_err, 0);
        chk("s23_pulses", pulses - p0, 5);
        chk("s23_latency", cyc - acc_cyc, 1);
        @(negedge clk);
        chk("s23_vld_1cyc", dec_vld, 0);
        chk("s23_idle", dec_busy, 0);
        repeat (3) @(negedge clk);
        chk("s23_hold_dout", dec_dout, 23);
        chk("s23_no_en_idle", naf_shft_en, 0);

        // 1,0,0,0,-3 -> 13
        set_stream(5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b10100, 5);
        start_stream();
        wait_vld();
        chk("s13_dout", dec_dout, 13);
        chk("s13_len", dec_len, 5);
        chk("s13_err", dec_err, 0);

        // +7 then illegal two-hot digit -> 14 with error
        set_stream(5'b00001, 5'b01100, 5'b0, 5'b0, 5'b0, 2);
        start_stream();
        wait_vld();
        chk("ill_err", dec_err, 1);
        chk("ill_len", dec_len, 2);
        chk("ill_dout", dec_dout, 14);

        // 23 again with hold and rdy stalls
        set_stream(5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5);
        p0 = pulses;
        start_stream();
        wait_pulses(p0 + 2);
        dec_hold = 1'b1;
        #1 chk("hold_en0", naf_shft_en, 0);
        @(negedge clk);
        chk("hold_en1", naf_shft_en, 0);
        chk("hold_pulses1", pulses - p0, 2);
        @(negedge clk);
        chk("hold_pulses2", pulses - p0, 2);
        dec_hold = 1'b0;
        wait_pulses(p0 + 3);
        naf_shft_rdy = 1'b0;
        #1 chk("rdy_low_en", naf_shft_en, 0);
        @(negedge clk);
        chk("rdy_low_pulses", pulses - p0, 3);
        chk("rdy_low_busy", dec_busy, 1);
        naf_shft_rdy = 1'b1;
        wait_vld();
        chk("stall_dout", dec_dout, 23);
        chk("stall_len", dec_len, 5);
        chk("stall_err", dec_err, 0);

        // single -5 digit -> negative result
        set_stream(5'b10010, 5'b0, 5'b0, 5'b0, 5'b0, 1);
        start_stream();
        wait_vld();
        chk("neg_err", dec_err, 1);
        chk("neg_len", dec_len, 1);

        // reset after two digits
        set_stream(5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5);
        p0 = pulses;
        start_stream();
        wait_pulses(p0 + 2);
        v0 = vld_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_dout", dec_dout, 0);
        chk("mrst_err", dec_err, 0);
        chk("mrst_len", dec_len, 0);
        chk("mrst_busy", dec_busy, 0);
        chk("mrst_en", naf_shft_en, 0);
        chk("mrst_vld", dec_vld, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mrst_no_vld", vld_cnt - v0, 0);

        // restart after three digits, then a full 23 stream
        p0 = pulses;
        v0 = vld_cnt;
        start_stream();
        wait_pulses(p0 + 3);
        naf_shft_rdy = 1'b0;
        load = 1'b1; dec_start = 1'b1;
        @(negedge clk);
        load = 1'b0; dec_start = 1'b0;
        chk("rs_busy", dec_busy, 1);
        naf_shft_rdy = 1'b1;
        wait_vld();
        chk("rs_dout", dec_dout, 23);
        chk("rs_len", dec_len, 5);
        chk("rs_err", dec_err, 0);
        repeat (5) @(negedge clk);
        chk("rs_single_vld", vld_cnt - v0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
